// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and one sync_fifo write port.
// slave = arbiter side, master = producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_valid_o;
    logic [DATA_WIDTH-1:0]         fifo_data_o;
    logic                          fifo_ready_i;
    logic [ID_WIDTH-1:0]           grant_id_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, fifo_ready_i,
        output req_ready_o, fifo_valid_o, fifo_data_o, grant_id_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, fifo_ready_i,
        input  req_ready_o, fifo_valid_o, fifo_data_o, grant_id_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter onto one FIFO write port; FIFO_ARB_BURST_LOCK_EN holds the grant until req_last_i.
// Latency: beat accepted in cycle N is on fifo_valid_o/fifo_data_o in cycle N+1, one beat per cycle.
// Backpressure: with the stage full and fifo_ready_i low, req_ready_o is all zero and the stage is frozen.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    logic                  out_vld_q, out_vld_d;
    beat_t                 out_beat_q, out_beat_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]    cand;
    logic                  win_vld;
    logic [ID_WIDTH-1:0]   win_id;
    logic [ID_WIDTH-1:0]   scan_idx;
    logic [DATA_WIDTH-1:0] win_dat;
    logic                  load_ok;
    logic                  accept;

`ifdef FIFO_ARB_BURST_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    lock_state_e           lock_state_q, lock_state_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;

    // While a burst owns the port, nobody else is even a candidate.
    always_comb begin
        cand = bus.req_valid_i;
        if (lock_state_q == LOCKED) begin
            cand = bus.req_valid_i & (NUM_REQ'(1) << lock_id_q);
        end
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_id_d    = lock_id_q;
        case (lock_state_q)
            UNLOCKED: begin
                if (accept && !bus.req_last_i[win_id]) begin
                    lock_state_d = LOCKED;
                    lock_id_d    = win_id;
                end
            end
            LOCKED: begin
                if (accept && bus.req_last_i[win_id]) begin
                    lock_state_d = UNLOCKED;
                end
            end
            default: lock_state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_state_q <= UNLOCKED;
            lock_id_q    <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_id_q    <= lock_id_d;
        end
    end
`else
    logic unused_last;

    assign cand        = bus.req_valid_i;
    assign unused_last = ^bus.req_last_i;
`endif

    // Scan from the slot after the last winner, wrapping, first candidate wins.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_WIDTH'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_vld && cand[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    assign win_dat = bus.req_data_i[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
    assign load_ok = !out_vld_q || bus.fifo_ready_i;
    assign accept  = win_vld && load_ok;

    assign bus.req_ready_o  = accept ? (NUM_REQ'(1) << win_id) : '0;
    assign bus.fifo_valid_o = out_vld_q;
    assign bus.fifo_data_o  = out_beat_q.dat;
    assign bus.grant_id_o   = out_beat_q.id;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_beat_d   = out_beat_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_vld_d      = 1'b1;
            out_beat_d.id  = win_id;
            out_beat_d.dat = win_dat;
            last_grant_d   = win_id;
        end else if (bus.fifo_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_vld_q    <= 1'b0;
            out_beat_q   <= '0;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            out_vld_q    <= out_vld_d;
            out_beat_q   <= out_beat_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, burst-lock and reset sequences, then random traffic against a model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one-deep stage, rotating priority, optional burst owner, and a beat ledger.
    typedef struct { int id; logic [W-1:0] d; } beat_t;
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_id, m_last, m_lock_id;
    bit          m_locked;
    beat_t       ledger[$];
    logic [N-1:0] prev_rdy;

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_id = 0; m_last = N - 1;
        m_locked = 0; m_lock_id = 0; ledger.delete(); prev_rdy = '0;
    endtask

    task automatic check_and_step(input string tag);
        int win;
        bit load_ok;
        logic [N-1:0] exp_rdy;
        beat_t b;
        chk({tag, "_fvalid"}, 32'(bus.fifo_valid_o), 32'(m_valid));
        chk({tag, "_fdata"},  32'(bus.fifo_data_o),  32'(m_data));
        chk({tag, "_gid"},    32'(bus.grant_id_o),   32'(m_id));
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (win < 0 && bus.req_valid_i[i] && (!m_locked || i == m_lock_id)) win = i;
        end
        load_ok = !m_valid || bus.fifo_ready_i;
        exp_rdy = (win >= 0 && load_ok) ? N'(1 << win) : '0;
        chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'(exp_rdy));
        prev_rdy = bus.req_ready_o;
        if (m_valid && bus.fifo_ready_i) begin
            if (ledger.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_ledger write with no accepted beat pending", tag);
            end else begin
                b = ledger.pop_front();
                chk({tag, "_wr_data"}, 32'(bus.fifo_data_o), 32'(b.d));
                chk({tag, "_wr_id"},   32'(bus.grant_id_o),  32'(b.id));
            end
        end
        if (win >= 0 && load_ok) begin
            m_valid = 1; m_id = win; m_last = win;
            m_data  = bus.req_data_i[win*W +: W];
            b.id = win; b.d = m_data;
            ledger.push_back(b);
            if (LOCK_ON) begin
                if (!m_locked && !bus.req_last_i[win]) begin
                    m_locked = 1; m_lock_id = win;
                end else if (m_locked && bus.req_last_i[win]) begin
                    m_locked = 0;
                end
            end
        end else if (bus.fifo_ready_i) begin
            m_valid = 0;
        end
    endtask

    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid_i[i] && !prev_rdy[i]) begin
                if ($urandom_range(7) == 0) bus.req_valid_i[i] = 1'b0;
            end else begin
                bus.req_valid_i[i]     = 1'($urandom_range(1));
                bus.req_data_i[i*W +: W] = W'($urandom);
                bus.req_last_i[i]      = 1'($urandom_range(1));
            end
        end
        bus.fifo_ready_i = ($urandom_range(3) != 0);
    endtask

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           fr;
        logic [N-1:0]   rdy;
        logic           fv;
        logic [W-1:0]   fd;
        logic [IW-1:0]  gid;
    } vec_t;

    function automatic vec_t mk(logic [N-1:0] v, logic [N*W-1:0] d, logic fr,
                                logic [N-1:0] rdy, logic fv, logic [W-1:0] fd, logic [IW-1:0] gid);
        vec_t r;
        r.v = v; r.d = d; r.fr = fr; r.rdy = rdy; r.fv = fv; r.fd = fd; r.gid = gid;
        return r;
    endfunction

    vec_t tbl[16];
    int   gseq[$];
    int   exp_lock_seq[6] = '{0, 1, 1, 1, 3, 0};

    initial begin
        logic [N*W-1:0] all_d = 32'h1312_1110;
        for (int r = 0; r < 16; r++) tbl[r] = mk(4'hF, all_d, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0);
        tbl[0]  = mk(4'hF, all_d, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
        tbl[1]  = mk(4'hF, all_d, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0);
        tbl[2]  = mk(4'hF, all_d, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1);
        tbl[3]  = mk(4'hF, all_d, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2);
        tbl[4]  = mk(4'hF, all_d, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3);
        tbl[10] = mk(4'hF, all_d, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0);
        tbl[11] = mk(4'hF, all_d, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1);
        tbl[12] = mk(4'h4, 32'h005A_0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
        tbl[13] = mk(4'h4, 32'h005B_0000, 1'b1, 4'b0100, 1'b1, 8'h5A, 2'd2);
        tbl[14] = mk(4'h0, 32'h005B_0000, 1'b1, 4'b0000, 1'b1, 8'h5B, 2'd2);
        tbl[15] = mk(4'h0, 32'h005B_0000, 1'b1, 4'b0000, 1'b0, 8'h5B, 2'd2);

        rstn = 1'b0;
        bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.fifo_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fvalid", 32'(bus.fifo_valid_o), 32'd0);
        chk("rst_fdata",  32'(bus.fifo_data_o),  32'd0);
        chk("rst_gid",    32'(bus.grant_id_o),   32'd0);
        chk("rst_rdy",    32'(bus.req_ready_o),  32'd0);

        // Directed table; every beat marked last so a lock build behaves per-beat here too.
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rstn = 1'b1;
            bus.req_valid_i = tbl[r].v; bus.req_data_i = tbl[r].d;
            bus.req_last_i = '1; bus.fifo_ready_i = tbl[r].fr;
            #1;
            chk($sformatf("tbl%0d_rdy", r),    32'(bus.req_ready_o),  32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_fvalid", r), 32'(bus.fifo_valid_o), 32'(tbl[r].fv));
            chk($sformatf("tbl%0d_fdata", r),  32'(bus.fifo_data_o),  32'(tbl[r].fd));
            chk($sformatf("tbl%0d_gid", r),    32'(bus.grant_id_o),   32'(tbl[r].gid));
        end

        // Burst lock: park the pointer on 0, then requester 1 bursts 3 beats alongside 0 and 3.
        if (LOCK_ON) begin
            int beats1 = 0;
            @(negedge clk);
            rstn = 1'b0;
            bus.req_valid_i = '0; bus.fifo_ready_i = 1'b1;
            model_reset();
            @(negedge clk);
            rstn = 1'b1;
            bus.req_valid_i = 4'b0001; bus.req_last_i = 4'b1111; bus.req_data_i = 32'h0000_00A0;
            #1;
            check_and_step("lock0");
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (prev_rdy[0]) bus.req_data_i[0*W +: W] = bus.req_data_i[0*W +: W] + 8'd1;
                if (prev_rdy[3]) bus.req_data_i[3*W +: W] = bus.req_data_i[3*W +: W] + 8'd1;
                if (prev_rdy[1]) beats1++;
                if (c == 0) bus.req_data_i[3*W +: W] = 8'hC0;
                bus.req_data_i[1*W +: W] = 8'hB0 + 8'(beats1);
                bus.req_valid_i = {1'b1, 1'b0, (beats1 < 3), 1'b1};
                bus.req_last_i  = {1'b1, 1'b1, (beats1 == 2), 1'b1};
                #1;
                if (bus.fifo_valid_o) gseq.push_back(int'(bus.grant_id_o));
                check_and_step($sformatf("lock%0d", c + 1));
            end
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("lock_order%0d", j), 32'((j < gseq.size()) ? gseq[j] : -1), 32'(exp_lock_seq[j]));
            end
        end

        // Random traffic with withdrawals and FIFO back-pressure.
        @(negedge clk);
        rstn = 1'b0;
        bus.req_valid_i = '0; bus.req_last_i = '0; bus.fifo_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            rand_drive();
            #1;
            check_and_step("rnd");
        end

        // Mid-stream reset with a beat staged.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.req_valid_i = 4'hF; bus.req_last_i = 4'hF; bus.fifo_ready_i = 1'b1;
            #1;
            check_and_step("pre_rst");
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_fvalid", 32'(bus.fifo_valid_o), 32'd0);
        chk("mid_rst_fdata",  32'(bus.fifo_data_o),  32'd0);
        chk("mid_rst_gid",    32'(bus.grant_id_o),   32'd0);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        bus.req_valid_i = 4'b0110; bus.req_data_i = 32'h0033_2200;
        #1;
        chk("post_rst_rdy", 32'(bus.req_ready_o), 32'b0010);
        check_and_step("post_rst0");
        @(negedge clk);
        #1;
        chk("post_rst_first_gid",  32'(bus.grant_id_o),  32'd1);
        chk("post_rst_first_data", 32'(bus.fifo_data_o), 32'h22);
        check_and_step("post_rst1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
